pipeline_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipeline; drives the `stall` inputs of the IF/ID/EX stage registers and the bubble/kill controls.
- Detects load-use hazards against the EX-stage load and sequences the flush window after a taken branch/jump reported by EX.
- Freezes the whole pipeline while the data memory has not acknowledged a request.
- Sits beside the stage modules; purely a controller, no datapath.

---
 rtl/pipeline_hazard_ctrl_if.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline stages (master) and the stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if;
  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic       rs1_used_ID;
  logic       rs2_used_ID;
  logic [4:0] rd_EX;
  logic [2:0] dm_rd_ctrl_EX;
  logic       branch_taken_EX;
  logic       mem_req;
  logic       mem_ready;
  logic       stall_IF;
  logic       stall_ID;
  logic       stall_EX;
  logic       bubble_EX;
  logic       kill_ID;
  logic [1:0] state_o;
  logic       mem_timeout;

  modport master (
    output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, dm_rd_ctrl_EX,
           branch_taken_EX, mem_req, mem_ready,
    input  stall_IF, stall_ID, stall_EX, bubble_EX, kill_ID, state_o, mem_timeout
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_EX, dm_rd_ctrl_EX,
           branch_taken_EX, mem_req, mem_ready,
    output stall_IF, stall_ID, stall_EX, bubble_EX, kill_ID, state_o, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush window, memory wait.
// Optional performance counters are enabled with `define HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_lu_stalls,
  output logic [31:0]           perf_flushes,
  output logic [31:0]           perf_mem_cycles
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_UNUSED   = 2'd3
  } state_t;

  localparam logic [3:0] LP_FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] LP_TIMEOUT      = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_flush_cnt;
  logic [3:0] w_flush_cnt_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_nxt;
  logic       r_timeout;
  logic       w_timeout_nxt;

  logic       w_load_use;
  logic       w_mem_stall;
  logic       w_stall_if;
  logic       w_stall_id;
  logic       w_stall_ex;
  logic       w_bubble_ex;
  logic       w_kill_id;
  logic       w_lu_stall;
  logic       w_br_accept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_load_use  = (hz.dm_rd_ctrl_EX != 3'd0) && (hz.rd_EX != 5'd0) &&
                       ((hz.rs1_used_ID && (hz.rs1_ID == hz.rd_EX)) ||
                        (hz.rs2_used_ID && (hz.rs2_ID == hz.rd_EX)));
  assign w_mem_stall = hz.mem_req && !hz.mem_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_timeout_nxt   = r_timeout;
    w_stall_if      = 1'b0;
    w_stall_id      = 1'b0;
    w_stall_ex      = 1'b0;
    w_bubble_ex     = 1'b0;
    w_kill_id       = 1'b0;
    w_lu_stall      = 1'b0;
    w_br_accept     = 1'b0;

    case (r_state)
      // MEM_WAIT without a stall behaves exactly like RUN for the pending hazards
      S_RUN, S_MEM_WAIT: begin
        if (w_mem_stall) begin
          w_stall_if     = 1'b1;
          w_stall_id     = 1'b1;
          w_stall_ex     = 1'b1;
          w_state_nxt    = S_MEM_WAIT;
          w_wait_cnt_nxt = (r_state == S_RUN) ? 8'd1 : sat_inc8(r_wait_cnt);
          if (w_wait_cnt_nxt >= LP_TIMEOUT) begin
            w_timeout_nxt = 1'b1;
          end
        end else begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = 8'd0;
          if (hz.branch_taken_EX) begin
            w_kill_id   = 1'b1;
            w_bubble_ex = 1'b1;
            w_br_accept = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_state_nxt     = S_FLUSH;
              w_flush_cnt_nxt = LP_FLUSH_RELOAD;
            end
          end else if (w_load_use) begin
            w_stall_if  = 1'b1;
            w_stall_id  = 1'b1;
            w_bubble_ex = 1'b1;
            w_lu_stall  = 1'b1;
          end
        end
      end

      S_FLUSH: begin
        if (w_mem_stall) begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
        end else begin
          w_kill_id   = 1'b1;
          w_bubble_ex = 1'b1;
          if (hz.branch_taken_EX) begin
            w_br_accept     = 1'b1;
            w_flush_cnt_nxt = LP_FLUSH_RELOAD;
          end else if (r_flush_cnt <= 4'd1) begin
            w_state_nxt     = S_RUN;
            w_flush_cnt_nxt = 4'd0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 4'd1;
          end
        end
      end

      default: begin
        w_state_nxt     = S_RUN;
        w_flush_cnt_nxt = 4'd0;
        w_wait_cnt_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_flush_cnt <= 4'd0;
      r_wait_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Outputs are forced low for as long as reset is held, regardless of inputs
  assign hz.stall_IF    = reset & w_stall_if;
  assign hz.stall_ID    = reset & w_stall_id;
  assign hz.stall_EX    = reset & w_stall_ex;
  assign hz.bubble_EX   = reset & w_bubble_ex;
  assign hz.kill_ID     = reset & w_kill_id;
  assign hz.state_o     = r_state;
  assign hz.mem_timeout = r_timeout;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_lu_stalls  <= 32'd0;
      perf_flushes    <= 32'd0;
      perf_mem_cycles <= 32'd0;
    end else begin
      perf_lu_stalls  <= perf_lu_stalls  + {31'd0, w_lu_stall};
      perf_flushes    <= perf_flushes    + {31'd0, w_br_accept};
      perf_mem_cycles <= perf_mem_cycles + {31'd0, w_stall_ex};
    end
  end
`endif

endmodule
